shiftrows_pipe: RTL and testbench

Parametrised, pipelined Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake. It supports 128/192/256-bit block widths (Nb = 4/6/8 columns) and a per-transaction direction bit. It sits between SubBytes and MixColumns in the round datapath of the crypto engine, and can be reused on the decrypt path. A sideband tag travels with each block, so upstream control can track rounds and channels without its own delay line.

---
 rtl/shiftrows_pipe.sv | 106 ++++++++++
 tb/tb_shiftrows_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftrows_pipe.sv
// shiftrows_pipe: pipelined Rijndael ShiftRows/InvShiftRows stage with valid/ready and sideband tag
module shiftrows_pipe #(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int W = 32 * NB;
    localparam int S = PIPE_STAGES;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $fatal(1, "shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $fatal(1, "shiftrows_pipe: PIPE_STAGES must be 1..4");
    end

    // Source column for output byte (r,c); NB=8 shifts rows 2 and 3 one column further
    function automatic int src_col(input logic inv, input int c, input int r);
        int off;
        off = (NB == 8 && r >= 2) ? r + 1 : r;
        return inv ? (c + NB - off) % NB : (c + off) % NB;
    endfunction

    logic [W-1:0]                perm;
    logic [S-1:0]                v_q, v_d;
    logic [S-1:0][W-1:0]         data_q, data_d;
    logic [S-1:0]                inv_q, inv_d;
    logic [S-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [S:0]                  ld;

    // Byte permutation applied in front of stage 0
    always_comb begin
        perm = '0;
        for (int c = 0; c < NB; c++)
            for (int r = 0; r < 4; r++)
                perm[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*src_col(in_inv, c, r)+r) -: 8];
    end

    // Advance chain from the output backwards: a stage loads when empty or when its successor moves
    always_comb begin
        ld = '0;
        ld[S] = out_ready;
        for (int i = S - 1; i >= 0; i--)
            ld[i] = !v_q[i] || ld[i+1];
    end

    assign in_ready = ld[0] && !flush;

    // Next state: stage 0 takes the permuted block, later stages shift; flush drops every valid
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        inv_d  = inv_q;
        tag_d  = tag_q;
        if (ld[0]) begin
            v_d[0]    = in_valid;
            data_d[0] = perm;
            inv_d[0]  = in_inv;
            tag_d[0]  = in_tag;
        end
        for (int i = 1; i < S; i++) begin
            if (ld[i]) begin
                v_d[i]    = v_q[i-1];
                data_d[i] = data_q[i-1];
                inv_d[i]  = inv_q[i-1];
                tag_d[i]  = tag_q[i-1];
            end
        end
        if (flush)
            v_d = '0;
    end

    // Stage registers; reset empties the pipe and zeroes the visible outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            data_q <= '0;
            inv_q  <= '0;
            tag_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            inv_q  <= inv_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = v_q[S-1];
    assign out_data  = data_q[S-1];
    assign out_inv   = inv_q[S-1];
    assign out_tag   = tag_q[S-1];
endmodule

// File: tb/tb_shiftrows_pipe.sv
// tb_shiftrows_pipe: table vectors plus scoreboarded random, backpressure, flush and reset sequences
module tb_shiftrows_pipe;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
    logic [127:0] a_in_data, a_out_data;
    logic [3:0]   a_in_tag, a_out_tag;
    logic         b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
    logic [255:0] b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;

    shiftrows_pipe #(.NB(4), .PIPE_STAGES(2), .TAG_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_inv(a_in_inv), .in_tag(a_in_tag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_inv(a_out_inv), .out_tag(a_out_tag));

    shiftrows_pipe #(.NB(8), .PIPE_STAGES(3), .TAG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv), .out_tag(b_out_tag));

    typedef struct {
        logic [255:0] data;
        logic         inv;
        logic [3:0]   tag;
    } exp_t;

    typedef struct {
        bit           sel;
        logic [255:0] din;
        logic         inv;
        logic [3:0]   tag;
        logic [255:0] exp;
    } vec_t;

    exp_t qa[$], qb[$];
    exp_t a_exp, b_exp;
    int nchk = 0, nerr = 0;
    bit a_acc, b_acc, b_stall = 0;
    logic [255:0] b_hd;
    logic b_hi;
    logic [3:0] b_ht;

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [255:0] RAMP8 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] FWD8 =
        256'h00050e13040912170_80d161b0c111a1f10151e0314190207181d060b1c010a0f >> 0;

    function automatic logic [255:0] ref_perm(input logic [255:0] d, input logic inv, input int nb);
        logic [255:0] o;
        int w, s, src;
        o = '0;
        w = 32 * nb;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                s = (nb == 8 && r > 1) ? r + 1 : r;
                src = inv ? (c + nb - s) % nb : (c + s) % nb;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One clock: record accepts, score emitted blocks, check stall stability, then step past the edge
    task automatic cyc();
        exp_t e;
        #1;
        a_acc = a_in_valid && a_in_ready;
        b_acc = b_in_valid && b_in_ready;
        if (a_acc) qa.push_back(a_exp);
        if (b_acc) qb.push_back(b_exp);
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_block", {128'b0, a_out_data}, 256'hx);
            else begin
                e = qa.pop_front();
                chk("a_data", {128'b0, a_out_data}, e.data);
                chk("a_inv", a_out_inv, e.inv);
                chk("a_tag", a_out_tag, e.tag);
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_block", b_out_data, 256'hx);
            else begin
                e = qb.pop_front();
                chk("b_data", b_out_data, e.data);
                chk("b_inv", b_out_inv, e.inv);
                chk("b_tag", b_out_tag, e.tag);
            end
        end
        if (b_stall) begin
            chk("b_hold_valid", b_out_valid, 1);
            chk("b_hold_data", b_out_data, b_hd);
            chk("b_hold_inv", b_out_inv, b_hi);
            chk("b_hold_tag", b_out_tag, b_ht);
        end
        b_stall = b_out_valid && !b_out_ready && !b_flush;
        b_hd = b_out_data;
        b_hi = b_out_inv;
        b_ht = b_out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [255:0] d, input logic inv, input logic [3:0] tag,
                        input logic [255:0] e);
        int n;
        bit acc;
        n = 0;
        if (sel) begin
            b_in_valid = 1; b_in_data = d; b_in_inv = inv; b_in_tag = tag; b_exp = '{e, inv, tag};
        end else begin
            a_in_valid = 1; a_in_data = d[127:0]; a_in_inv = inv; a_in_tag = tag; a_exp = '{e, inv, tag};
        end
        do begin
            cyc();
            n++;
            acc = sel ? b_acc : a_acc;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        a_in_valid = 0;
        b_in_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        a_out_ready = 1;
        b_out_ready = 1;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_left", qa.size() + qb.size(), 0);
    endtask

    function automatic logic [255:0] rnd(input int nb);
        logic [255:0] x;
        x = '0;
        for (int i = 0; i < nb; i++) x[32*i +: 32] = $urandom;
        return x;
    endfunction

    vec_t vec[6];

    initial begin
        logic [255:0] x, y;
        logic inv;
        int sent, cycles, n;
        vec[0] = '{0, FIPS_IN, 0, 4'd5, FIPS_OUT};
        vec[1] = '{0, FIPS_OUT, 1, 4'd6, FIPS_IN};
        vec[2] = '{0, 128'h000102030405060708090a0b0c0d0e0f, 0, 4'd1,
                   128'h00050a0f04090e03080d02070c01060b};
        vec[3] = '{0, 128'h000102030405060708090a0b0c0d0e0f, 1, 4'd2,
                   128'h000d0a0704010e0b0805020f0c090603};
        vec[4] = '{1, RAMP8, 0, 4'd3,
                   256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f};
        vec[5] = '{1, RAMP8, 1, 4'd4,
                   256'h001d161304011a1708051e1b0c09021f100d060314110a0718150e0b1c19120f};

        rst_n = 0;
        {a_flush, a_in_valid, a_in_inv, b_flush, b_in_valid, b_in_inv} = '0;
        a_in_data = '0; b_in_data = '0; a_in_tag = '0; b_in_tag = '0;
        a_out_ready = 1; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_data", b_out_data, 0);
        chk("rst_b_inv_tag", {b_out_inv, b_out_tag}, 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_a_ready", a_in_ready, 1);
        chk("rst_b_ready", b_in_ready, 1);

        send(0, FIPS_IN, 0, 4'd5, FIPS_OUT);
        chk("fips_lat_early", a_out_valid, 0);
        cyc();
        chk("fips_lat_valid", a_out_valid, 1);
        chk("fips_data", {128'b0, a_out_data}, FIPS_OUT);
        chk("fips_tag", a_out_tag, 5);
        drain();

        for (int i = 0; i < 6; i++) begin
            send(vec[i].sel, vec[i].din, vec[i].inv, vec[i].tag, vec[i].exp);
            drain();
        end

        send(1, RAMP8, 0, 4'd7, ref_perm(RAMP8, 0, 8));
        n = 0;
        while (!b_out_valid && n < 10) begin cyc(); n++; end
        chk("wrap_r3c0", b_out_data[255-8*3 -: 8], 8'h13);
        chk("wrap_r2c7", b_out_data[255-8*30 -: 8], 8'h0a);
        drain();

        for (int k = 0; k < 500; k++) begin
            x = rnd(4);
            y = ref_perm(x, 0, 4);
            send(0, x, 0, 4'(k), y);
            send(0, y, 1, 4'(k + 1), x);
        end
        drain();

        sent = 0;
        cycles = 0;
        b_in_valid = 0;
        while (sent < 200 && cycles < 5000) begin
            b_out_ready = ($urandom_range(99) < 30);
            if (!b_in_valid) begin
                x = rnd(8);
                inv = 1'($urandom_range(1));
                b_in_data = x; b_in_inv = inv; b_in_tag = 4'($urandom);
                b_exp = '{ref_perm(x, inv, 8), inv, b_in_tag};
                b_in_valid = 1;
            end
            cyc();
            cycles++;
            if (b_acc) begin sent++; b_in_valid = 0; end
        end
        b_in_valid = 0;
        chk("bp_sent", sent, 200);
        drain();

        b_out_ready = 0;
        for (int k = 0; k < 3; k++) send(1, rnd(8), 0, 4'(k), 0);
        chk("full_ready_low", b_in_ready, 0);
        chk("full_valid", b_out_valid, 1);
        b_flush = 1;
        b_in_valid = 1;
        b_in_data = rnd(8);
        cyc();
        chk("flush_no_accept", b_acc, 0);
        b_flush = 0;
        b_in_valid = 0;
        chk("flush_valid_low", b_out_valid, 0);
        qb.delete();
        b_out_ready = 1;
        repeat (6) begin
            cyc();
            chk("flush_no_stale", b_out_valid, 0);
        end

        b_out_ready = 0;
        for (int k = 0; k < 2; k++) send(1, rnd(8), 1, 4'(k + 9), 0);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", b_out_valid, 0);
        chk("mid_rst_data", b_out_data, 0);
        chk("mid_rst_inv_tag", {b_out_inv, b_out_tag}, 0);
        qb.delete();
        b_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", b_in_ready, 1);
        chk("post_rst_valid", b_out_valid, 0);
        b_out_ready = 1;
        send(1, RAMP8, 1, 4'd8, vec[5].exp);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
